// File: rtl/parking_pkg.sv
// Shared time-of-day constants and types for the parking time base.
// Pure declarations: no latency, no flow control.
package parking_pkg;
  localparam int HOUR_W       = 5;
  localparam int MIN_W        = 6;
  localparam int MIN_PER_HOUR = 60;
  localparam int HOUR_PER_DAY = 24;

  localparam logic [HOUR_W-1:0] MAX_HOUR = HOUR_W'(HOUR_PER_DAY - 1);
  localparam logic [MIN_W-1:0]  MAX_MIN  = MIN_W'(MIN_PER_HOUR - 1);

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
  } time_of_day_t;

  function automatic logic time_valid(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m);
    return (h <= MAX_HOUR) && (m <= MAX_MIN);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clk cycles into minute ticks; tick is combinational on the terminal count.
// No backpressure: enable low freezes the count, clear restarts it at 0.
module tick_prescaler #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MIN - 1);

  logic [CW-1:0] cnt;

  // A clearing load takes the cycle, so it must not also produce a minute.
  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/parking_time_base.sv
// Minute/hour/day time base with load, rollover strobes and sticky day overflow; updates one edge after the terminal prescale count.
// No backpressure; optional daily alarm compiled in with PARKING_TIME_ALARM_EN.
module parking_time_base
  import parking_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int DAY_W         = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic [MIN_W-1:0]  load_minute,
  input  logic [DAY_W-1:0]  load_day,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [DAY_W-1:0]  day,
  output logic              minute_tick,
  output logic              hour_tick,
  output logic              day_tick,
  output logic              day_overflow,
  output logic              load_err
`ifdef PARKING_TIME_ALARM_EN
  ,
  input  logic              alarm_set,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_minute,
  output logic              alarm_hit
`endif
);
  logic tick;
  logic accept;
  logic min_wrap, hour_wrap, day_wrap;
  logic [HOUR_W-1:0] next_hour;
  logic [MIN_W-1:0]  next_minute;
  logic [DAY_W-1:0]  next_day;

  assign accept = load && time_valid(load_hour, load_minute);

  tick_prescaler #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (accept),
    .tick   (tick)
  );

  always_comb begin
    min_wrap    = (minute == MAX_MIN);
    hour_wrap   = min_wrap && (hour == MAX_HOUR);
    day_wrap    = hour_wrap && (day == '1);
    next_minute = min_wrap ? '0 : minute + 1'b1;
    next_hour   = hour;
    next_day    = day;
    if (min_wrap)
      next_hour = (hour == MAX_HOUR) ? '0 : hour + 1'b1;
    if (hour_wrap)
      next_day = day + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hour         <= '0;
      minute       <= '0;
      day          <= '0;
      minute_tick  <= 1'b0;
      hour_tick    <= 1'b0;
      day_tick     <= 1'b0;
      day_overflow <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      minute_tick <= 1'b0;
      hour_tick   <= 1'b0;
      day_tick    <= 1'b0;
      load_err    <= 1'b0;
      if (accept) begin
        hour         <= load_hour;
        minute       <= load_minute;
        day          <= load_day;
        day_overflow <= 1'b0;
      end else begin
        // A rejected load only flags the error; counting carries on as usual.
        load_err <= load;
        if (tick) begin
          minute      <= next_minute;
          hour        <= next_hour;
          day         <= next_day;
          minute_tick <= 1'b1;
          hour_tick   <= min_wrap;
          day_tick    <= hour_wrap;
          if (day_wrap)
            day_overflow <= 1'b1;
        end
      end
    end
  end

`ifdef PARKING_TIME_ALARM_EN
  time_of_day_t alarm_time;
  logic         alarm_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_time  <= '0;
      alarm_armed <= 1'b0;
      alarm_hit   <= 1'b0;
    end else begin
      // Compare against the advanced time so the hit lands with minute_tick.
      alarm_hit <= tick && !accept && alarm_armed &&
                   (next_hour == alarm_time.hour) && (next_minute == alarm_time.minute);
      if (alarm_set && time_valid(alarm_hour, alarm_minute)) begin
        alarm_time.hour   <= alarm_hour;
        alarm_time.minute <= alarm_minute;
        alarm_armed       <= 1'b1;
      end
    end
  end
`endif
endmodule
